// File: rtl/logic_sweep_unit.sv
// logic_sweep_unit
//   Self-sequencing stimulus/response source. Walks an N_IN-bit vector through
//   all 2^N_IN values in ascending order, holding each for HOLD_CYCLES cycles,
//   and presents registered AND/OR/NAND/NOR/XOR/NOT-of-MSB results of the
//   vector that is currently on vec.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high; wins over start and pause
//   start        begin a sweep (honoured in IDLE or DONE only)
//   pause        freeze vector and dwell counter while high (RUN only)
//   vec          current input vector (vec[N_IN-1] is input "a")
//   and_out      &vec
//   or_out       |vec
//   nand_out     ~&vec
//   nor_out      ~|vec
//   xor_out      ^vec
//   not_msb      ~vec[N_IN-1]
//   vec_valid    one-cycle pulse on the first cycle of each new vector
//   busy         high in RUN
//   done         high in DONE (sticky until restart or reset)
//   sweep_count  completed full sweeps, wraps modulo 2^CNT_W
module logic_sweep_unit #(
    parameter int N_IN        = 3,
    parameter int HOLD_CYCLES = 20,
    parameter int LOOP        = 0,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    output logic [N_IN-1:0]  vec,
    output logic             and_out,
    output logic             or_out,
    output logic             nand_out,
    output logic             nor_out,
    output logic             xor_out,
    output logic             not_msb,
    output logic             vec_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sweep_count
);

    // Dwell counter wide enough to hold HOLD_CYCLES-1, at least one bit.
    localparam int DW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [DW-1:0]   DWELL_LAST = DW'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0] VEC_LAST   = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweepStateT;

    sweepStateT        state, stateNext;
    logic [DW-1:0]     dwell, dwellNext;
    logic [N_IN-1:0]   vecNext;
    logic [CNT_W-1:0]  countNext;
    logic              validNext;
    logic              loadVec;     // a new vector is presented on this edge

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            dwell <= '0;
        end else begin
            state <= stateNext;
            dwell <= dwellNext;
        end
    end

    always_comb begin
        stateNext = state;
        dwellNext = dwell;
        vecNext   = vec;
        countNext = sweep_count;
        validNext = 1'b0;
        loadVec   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    stateNext = RUN;
                    vecNext   = '0;
                    dwellNext = '0;
                    validNext = 1'b1;
                    loadVec   = 1'b1;
                end
            end
            RUN: begin
                // Pause takes precedence over a dwell expiry on the same edge.
                if (!pause) begin
                    if (dwell == DWELL_LAST) begin
                        dwellNext = '0;
                        if (vec == VEC_LAST) begin
                            countNext = sweep_count + 1'b1;
                            if (LOOP != 0) begin
                                vecNext   = '0;
                                validNext = 1'b1;
                                loadVec   = 1'b1;
                            end else begin
                                // Vector and gate results keep the all-ones values.
                                stateNext = DONE;
                            end
                        end else begin
                            vecNext   = vec + 1'b1;
                            validNext = 1'b1;
                            loadVec   = 1'b1;
                        end
                    end else begin
                        dwellNext = dwell + 1'b1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Gate results are computed from the vector being loaded so they appear on
    // the same cycle as vec. They only update on a load, so after reset all
    // of them (including nand/nor) sit at 0 until the first start.
    always_ff @(posedge clk) begin
        if (reset) begin
            vec         <= '0;
            and_out     <= 1'b0;
            or_out      <= 1'b0;
            nand_out    <= 1'b0;
            nor_out     <= 1'b0;
            xor_out     <= 1'b0;
            not_msb     <= 1'b0;
            vec_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sweep_count <= '0;
        end else begin
            vec         <= vecNext;
            vec_valid   <= validNext;
            busy        <= (stateNext == RUN);
            done        <= (stateNext == DONE);
            sweep_count <= countNext;
            if (loadVec) begin
                and_out  <= &vecNext;
                or_out   <= |vecNext;
                nand_out <= ~&vecNext;
                nor_out  <= ~|vecNext;
                xor_out  <= ^vecNext;
                not_msb  <= ~vecNext[N_IN-1];
            end
        end
    end

endmodule

// File: tb/tb_logic_sweep_unit.sv
module tb_logic_sweep_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // d0: N_IN=3, HOLD=4, LOOP=0
    logic       start0, pause0;
    logic [2:0] vec0;
    logic       and0, or0, nand0, nor0, xor0, not0, valid0, busy0, done0;
    logic [7:0] cnt0;
    // d1: N_IN=3, HOLD=1, LOOP=1, CNT_W=2
    logic       start1, pause1;
    logic [2:0] vec1;
    logic       and1, or1, nand1, nor1, xor1, not1, valid1, busy1, done1;
    logic [1:0] cnt1;
    // d2: N_IN=1, HOLD=2, LOOP=0
    logic       start2, pause2;
    logic [0:0] vec2;
    logic       and2, or2, nand2, nor2, xor2, not2, valid2, busy2, done2;
    logic [7:0] cnt2;

    logic_sweep_unit #(.N_IN(3), .HOLD_CYCLES(4), .LOOP(0), .CNT_W(8)) d0 (
        .clk(clk), .reset(reset), .start(start0), .pause(pause0), .vec(vec0),
        .and_out(and0), .or_out(or0), .nand_out(nand0), .nor_out(nor0),
        .xor_out(xor0), .not_msb(not0), .vec_valid(valid0), .busy(busy0),
        .done(done0), .sweep_count(cnt0));

    logic_sweep_unit #(.N_IN(3), .HOLD_CYCLES(1), .LOOP(1), .CNT_W(2)) d1 (
        .clk(clk), .reset(reset), .start(start1), .pause(pause1), .vec(vec1),
        .and_out(and1), .or_out(or1), .nand_out(nand1), .nor_out(nor1),
        .xor_out(xor1), .not_msb(not1), .vec_valid(valid1), .busy(busy1),
        .done(done1), .sweep_count(cnt1));

    logic_sweep_unit #(.N_IN(1), .HOLD_CYCLES(2), .LOOP(0), .CNT_W(8)) d2 (
        .clk(clk), .reset(reset), .start(start2), .pause(pause2), .vec(vec2),
        .and_out(and2), .or_out(or2), .nand_out(nand2), .nor_out(nor2),
        .xor_out(xor2), .not_msb(not2), .vec_valid(valid2), .busy(busy2),
        .done(done2), .sweep_count(cnt2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start0 = 1'b1; pause0 = 1'b1;
        tick(); tick();
        checks++;
        if ({vec0, and0, or0, nand0, nor0, xor0, not0, valid0, busy0, done0, cnt0} !== 20'h0) begin
            failures++;
            $display("FAIL reset_d0 got=%h want=0",
                     {vec0, and0, or0, nand0, nor0, xor0, not0, valid0, busy0, done0, cnt0});
        end
        checks++;
        if ({vec1, and1, or1, nand1, nor1, xor1, not1, valid1, busy1, done1, cnt1} !== 14'h0) begin
            failures++;
            $display("FAIL reset_d1 got=%h want=0",
                     {vec1, and1, or1, nand1, nor1, xor1, not1, valid1, busy1, done1, cnt1});
        end
        checks++;
        if ({vec2, and2, or2, nand2, nor2, xor2, not2, valid2, busy2, done2, cnt2} !== 18'h0) begin
            failures++;
            $display("FAIL reset_d2 got=%h want=0",
                     {vec2, and2, or2, nand2, nor2, xor2, not2, valid2, busy2, done2, cnt2});
        end
        reset = 1'b0; start0 = 1'b0;
        tick(); tick(); tick();
        pause0 = 1'b0;
        checks++;
        if ({vec0, and0, or0, nand0, nor0, xor0, not0, valid0, busy0, done0, cnt0} !== 20'h0) begin
            failures++;
            $display("FAIL idle_hold_d0 got=%h want=0",
                     {vec0, and0, or0, nand0, nor0, xor0, not0, valid0, busy0, done0, cnt0});
        end
    endtask

    task automatic test_sweep();
        int validCnt = 0;
        logic [2:0] ev;
        logic [5:0] eg, gg;
        start0 = 1'b1; tick(); start0 = 1'b0;
        for (int c = 0; c < 32; c++) begin
            ev = 3'(c / 4);
            eg = {&ev, |ev, ~&ev, ~|ev, ^ev, ~ev[2]};
            gg = {and0, or0, nand0, nor0, xor0, not0};
            if (valid0) validCnt++;
            checks++;
            if (vec0 !== ev || gg !== eg || valid0 !== (c % 4 == 0) || busy0 !== 1'b1 || done0 !== 1'b0) begin
                failures++;
                $display("FAIL sweep_c%0d got vec=%0d g=%b v=%b b=%b d=%b want vec=%0d g=%b v=%b b=1 d=0",
                         c, vec0, gg, valid0, busy0, done0, ev, eg, (c % 4 == 0));
            end
            if (c == 12) begin
                checks++;
                if (gg !== 6'b011001) begin
                    failures++;
                    $display("FAIL gates_vec3 got=%b want=011001", gg);
                end
            end
            if (c == 28) begin
                checks++;
                if (gg !== 6'b110010) begin
                    failures++;
                    $display("FAIL gates_vec7 got=%b want=110010", gg);
                end
            end
            tick();
        end
        checks++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || vec0 !== 3'd7 || cnt0 !== 8'd1 || valid0 !== 1'b0 || validCnt != 8) begin
            failures++;
            $display("FAIL sweep_end got d=%b b=%b vec=%0d cnt=%0d v=%b pulses=%0d want d=1 b=0 vec=7 cnt=1 v=0 pulses=8",
                     done0, busy0, vec0, cnt0, valid0, validCnt);
        end
    endtask

    task automatic test_restart();
        start0 = 1'b1; tick(); start0 = 1'b0;
        checks++;
        if (vec0 !== 3'd0 || done0 !== 1'b0 || busy0 !== 1'b1 || valid0 !== 1'b1 || cnt0 !== 8'd1) begin
            failures++;
            $display("FAIL restart got vec=%0d d=%b b=%b v=%b cnt=%0d want vec=0 d=0 b=1 v=1 cnt=1",
                     vec0, done0, busy0, valid0, cnt0);
        end
        for (int c = 1; c <= 32; c++) tick();
        checks++;
        if (done0 !== 1'b1 || cnt0 !== 8'd2) begin
            failures++;
            $display("FAIL restart_end got d=%b cnt=%0d want d=1 cnt=2", done0, cnt0);
        end
    endtask

    task automatic test_pause();
        int validCnt;
        int doneEdge = -1;
        int vecTwoCycles = 0;
        start0 = 1'b1; tick(); start0 = 1'b0;
        validCnt = valid0 ? 1 : 0;
        for (int c = 1; c <= 45; c++) begin
            pause0 = (c >= 10 && c <= 14);
            tick();
            if (valid0) validCnt++;
            if (busy0 && vec0 == 3'd2) vecTwoCycles++;
            if (done0 && doneEdge < 0) doneEdge = c;
            if (c == 14) begin
                checks++;
                if (vec0 !== 3'd2 || valid0 !== 1'b0) begin
                    failures++;
                    $display("FAIL pause_frozen got vec=%0d v=%b want vec=2 v=0", vec0, valid0);
                end
            end
        end
        pause0 = 1'b0;
        checks++;
        if (doneEdge != 37) begin
            failures++;
            $display("FAIL pause_done_edge got=%0d want=37", doneEdge);
        end
        checks++;
        if (validCnt != 8 || vecTwoCycles != 9) begin
            failures++;
            $display("FAIL pause_counts got pulses=%0d vec2cyc=%0d want pulses=8 vec2cyc=9", validCnt, vecTwoCycles);
        end
        checks++;
        if (cnt0 !== 8'd3) begin
            failures++;
            $display("FAIL pause_count got=%0d want=3", cnt0);
        end
    endtask

    task automatic test_start_ignored_and_reset();
        start0 = 1'b1; tick(); start0 = 1'b0;
        for (int c = 1; c <= 20; c++) tick();
        checks++;
        if (vec0 !== 3'd5) begin
            failures++;
            $display("FAIL at_vec5 got=%0d want=5", vec0);
        end
        start0 = 1'b1; tick(); start0 = 1'b0;
        checks++;
        if (vec0 !== 3'd5 || valid0 !== 1'b0 || busy0 !== 1'b1) begin
            failures++;
            $display("FAIL start_in_run got vec=%0d v=%b b=%b want vec=5 v=0 b=1", vec0, valid0, busy0);
        end
        tick();
        reset = 1'b1; start0 = 1'b1; tick(); reset = 1'b0; start0 = 1'b0;
        checks++;
        if ({vec0, and0, or0, nand0, nor0, xor0, not0, valid0, busy0, done0, cnt0} !== 20'h0) begin
            failures++;
            $display("FAIL reset_mid_run got=%h want=0",
                     {vec0, and0, or0, nand0, nor0, xor0, not0, valid0, busy0, done0, cnt0});
        end
        tick();
        checks++;
        if (busy0 !== 1'b0 || vec0 !== 3'd0) begin
            failures++;
            $display("FAIL idle_after_reset got b=%b vec=%0d want b=0 vec=0", busy0, vec0);
        end
        start0 = 1'b1; tick(); start0 = 1'b0;
        checks++;
        if ({vec0, valid0, and0, or0, nand0, nor0, xor0, not0} !== 10'b000_1_001101) begin
            failures++;
            $display("FAIL start_after_reset got=%b want=0001001101",
                     {vec0, valid0, and0, or0, nand0, nor0, xor0, not0});
        end
        for (int c = 1; c <= 4; c++) tick();
        checks++;
        if (vec0 !== 3'd1 || valid0 !== 1'b1) begin
            failures++;
            $display("FAIL second_vec got vec=%0d v=%b want vec=1 v=1", vec0, valid0);
        end
    endtask

    task automatic test_loop();
        int expCnt[5] = '{1, 2, 3, 0, 1};
        start1 = 1'b1; tick(); start1 = 1'b0;
        checks++;
        if (vec1 !== 3'd0 || valid1 !== 1'b1) begin
            failures++;
            $display("FAIL loop_start got vec=%0d v=%b want vec=0 v=1", vec1, valid1);
        end
        for (int c = 1; c <= 40; c++) begin
            tick();
            checks++;
            if (vec1 !== 3'(c % 8) || valid1 !== 1'b1 || busy1 !== 1'b1 || done1 !== 1'b0) begin
                failures++;
                $display("FAIL loop_c%0d got vec=%0d v=%b b=%b d=%b want vec=%0d v=1 b=1 d=0",
                         c, vec1, valid1, busy1, done1, c % 8);
            end
            if (c % 8 == 0) begin
                checks++;
                if (cnt1 !== 2'(expCnt[c / 8 - 1])) begin
                    failures++;
                    $display("FAIL loop_count_e%0d got=%0d want=%0d", c, cnt1, expCnt[c / 8 - 1]);
                end
            end
        end
    endtask

    task automatic test_n1();
        logic ev;
        pause2 = 1'b1; tick(); pause2 = 1'b0;
        checks++;
        if (busy2 !== 1'b0 || vec2 !== 1'b0 || valid2 !== 1'b0) begin
            failures++;
            $display("FAIL n1_pause_idle got b=%b vec=%b v=%b want 0 0 0", busy2, vec2, valid2);
        end
        start2 = 1'b1; tick(); start2 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            ev = (c >= 2);
            checks++;
            if (vec2 !== ev || not2 !== ~ev || xor2 !== ev || valid2 !== (c % 2 == 0) || done2 !== 1'b0) begin
                failures++;
                $display("FAIL n1_c%0d got vec=%b not=%b xor=%b v=%b d=%b want vec=%b not=%b xor=%b v=%b d=0",
                         c, vec2, not2, xor2, valid2, done2, ev, ~ev, ev, (c % 2 == 0));
            end
            tick();
        end
        checks++;
        if (done2 !== 1'b1 || cnt2 !== 8'd1 || vec2 !== 1'b1 || busy2 !== 1'b0) begin
            failures++;
            $display("FAIL n1_done got d=%b cnt=%0d vec=%b b=%b want d=1 cnt=1 vec=1 b=0",
                     done2, cnt2, vec2, busy2);
        end
    endtask

    initial begin
        reset = 1'b1;
        start0 = 1'b0; pause0 = 1'b0;
        start1 = 1'b0; pause1 = 1'b0;
        start2 = 1'b0; pause2 = 1'b0;
        test_reset();
        test_sweep();
        test_restart();
        test_pause();
        test_start_ignored_and_reset();
        test_loop();
        test_n1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
